// File: rtl/display_mux.sv
// Two-digit seven-segment time multiplexer: synchronizes two hex inputs and
// alternates them on cur_s with a blanking gap around every digit swap.
module display_mux #(
    parameter int HOLD_CYCLES  = 20000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] s0,
    input  logic [3:0] s1,
    output logic [3:0] cur_s,
    output logic       digit_sel,
    output logic       an0_n,
    output logic       an1_n
);

    localparam int MAX_DUR = (HOLD_CYCLES > BLANK_CYCLES) ? HOLD_CYCLES : BLANK_CYCLES;
    localparam int CW      = $clog2(MAX_DUR + 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    typedef enum logic [3:0] {
        BLANK1 = 4'b0001,
        SHOW0  = 4'b0010,
        BLANK0 = 4'b0100,
        SHOW1  = 4'b1000
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      s0_meta_q, s0_sync_q;
    logic [3:0]      s1_meta_q, s1_sync_q;
    logic            digit_sel_q, digit_sel_d;
    logic [3:0]      cur_s_q, cur_s_d;
    logic            last;

    always_comb begin
        last    = ((state_q == SHOW0) || (state_q == SHOW1)) ? (cnt_q == HOLD_LAST)
                                                             : (cnt_q == BLANK_LAST);
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
            cnt_d = '0;
            case (state_q)
                BLANK1:  state_d = SHOW0;
                SHOW0:   state_d = BLANK0;
                BLANK0:  state_d = SHOW1;
                default: state_d = BLANK1;
            endcase
        end
        // Selecting from the next state makes cur_s swap on the edge entering BLANK.
        digit_sel_d = (state_d == BLANK0) || (state_d == SHOW1);
        cur_s_d     = digit_sel_d ? s1_sync_q : s0_sync_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= BLANK1;
            cnt_q       <= '0;
            s0_meta_q   <= '0;
            s0_sync_q   <= '0;
            s1_meta_q   <= '0;
            s1_sync_q   <= '0;
            digit_sel_q <= 1'b0;
            cur_s_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s0_meta_q   <= s0;
            s0_sync_q   <= s0_meta_q;
            s1_meta_q   <= s1;
            s1_sync_q   <= s1_meta_q;
            digit_sel_q <= digit_sel_d;
            cur_s_q     <= cur_s_d;
        end
    end

    assign an0_n     = (state_q != SHOW0);
    assign an1_n     = (state_q != SHOW1);
    assign cur_s     = cur_s_q;
    assign digit_sel = digit_sel_q;

endmodule
